// File: rtl/crc8_arbiter_pkg.sv
// Shared types and defaults for the round-robin arbiter in front of the CRC8816 engine.
// Package name is kept short because every arbiter file imports it.
package crc8_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } state_t;

  localparam int DEFAULT_NUM_REQ      = 4;
  localparam int DEFAULT_DONE_TIMEOUT = 64;

  // Next requester index after idx, wrapping to 0 past n-1.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/crc8_arbiter_if.sv
// Bundle of requester, engine and response signals around the CRC8816 arbiter.
// slave = arbiter side, master = the surrounding environment (sources, engine, sink).
interface crc8_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_last;
  logic [NUM_REQ-1:0][7:0] req_data;
  logic [NUM_REQ-1:0]      req_ready;

  logic                    crc_valid;
  logic                    crc_last;
  logic [7:0]              crc_data;
  logic                    crc_done;
  logic                    crc_match;
  logic [7:0]              crc_crc8;

  logic                    resp_valid;
  logic [ID_W-1:0]         resp_id;
  logic                    resp_match;
  logic [7:0]              resp_crc8;
  logic                    resp_err;

  modport slave (
    input  req_valid, req_last, req_data,
    input  crc_done, crc_match, crc_crc8,
    output req_ready,
    output crc_valid, crc_last, crc_data,
    output resp_valid, resp_id, resp_match, resp_crc8, resp_err
  );

  modport master (
    output req_valid, req_last, req_data,
    output crc_done, crc_match, crc_crc8,
    input  req_ready,
    input  crc_valid, crc_last, crc_data,
    input  resp_valid, resp_id, resp_match, resp_crc8, resp_err
  );

endinterface

// File: rtl/crc8_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request bit at or after ptr, wrapping.
// found is low when no request bit is set; idx is 0 in that case.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    idx,
  output logic               found
);

  logic [NUM_REQ-1:0]           rot;
  logic [NUM_REQ-1:0][ID_W-1:0] sel_tab;

  // rot[k] is the request k positions after ptr; sel_tab[k] is its real index.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [ID_W:0] sum;
    assign sum         = {1'b0, ptr} + (ID_W+1)'(gi);
    assign sel_tab[gi] = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                                                      : ID_W'(sum);
    assign rot[gi]     = req[sel_tab[gi]];
  end

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        idx   = sel_tab[k];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/crc8_arbiter.sv
// Shares one CRC8816 engine between NUM_REQ byte-stream requesters, one whole packet at
// a time, and returns the engine result (or a timeout error) tagged with the owner index.
module crc8_arbiter
  import crc8_arb_pkg::*;
#(
  parameter int NUM_REQ      = DEFAULT_NUM_REQ,
  parameter int ID_W         = $clog2(NUM_REQ),
  parameter int DONE_TIMEOUT = DEFAULT_DONE_TIMEOUT
) (
  input logic           clk,
  input logic           reset,
  crc8_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_STREAM = STREAM;
  localparam logic [1:0] ST_WAIT   = WAIT_DONE;
  localparam logic [1:0] ST_RESP   = RESP;

  localparam int CNT_W = $clog2(DONE_TIMEOUT + 1);

  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]    resp_id_q, resp_id_d;
  logic               resp_match_q, resp_match_d;
  logic [7:0]         resp_crc8_q, resp_crc8_d;
  logic               resp_err_q, resp_err_d;

  logic [ID_W-1:0]    pick_idx;
  logic               pick_found;
  logic [NUM_REQ-1:0] grant_oh;
  logic               in_stream;
  logic               g_valid;
  logic               g_last;
  logic [7:0]         g_data;
  logic               timeout_hit;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
    assign grant_oh[gi] = (grant_id_q == ID_W'(gi));
  end

  assign in_stream = (state_q == ST_STREAM);
  assign g_valid   = bus.req_valid[grant_id_q];
  assign g_last    = bus.req_last[grant_id_q];
  assign g_data    = bus.req_data[grant_id_q];

  // The counter is cleared by the last beat, so its next value equals the number of
  // cycles elapsed since that beat; the response then lands DONE_TIMEOUT cycles after it.
  assign timeout_hit = ((cnt_q + CNT_W'(1)) == CNT_W'(DONE_TIMEOUT - 1));

  always_comb begin
    bus.req_ready = '0;
    bus.crc_valid = 1'b0;
    bus.crc_last  = 1'b0;
    bus.crc_data  = 8'h00;
    if (in_stream) begin
      bus.req_ready = grant_oh;
      bus.crc_valid = g_valid;
      bus.crc_last  = g_last;
      bus.crc_data  = g_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_match_d = resp_match_q;
    resp_crc8_d  = resp_crc8_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          state_d    = ST_STREAM;
        end
      end

      ST_STREAM: begin
        if (g_valid && g_last) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A done on the final count takes priority over the timeout.
        if (bus.crc_done) begin
          resp_valid_d = 1'b1;
          resp_id_d    = grant_id_q;
          resp_match_d = bus.crc_match;
          resp_crc8_d  = bus.crc_crc8;
          resp_err_d   = 1'b0;
          state_d      = ST_RESP;
        end else if (timeout_hit) begin
          resp_valid_d = 1'b1;
          resp_id_d    = grant_id_q;
          resp_match_d = 1'b0;
          resp_crc8_d  = 8'h00;
          resp_err_d   = 1'b1;
          state_d      = ST_RESP;
        end
      end

      ST_RESP: begin
        rr_ptr_d = ID_W'(wrap_inc(int'(grant_id_q), NUM_REQ));
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_match_q <= 1'b0;
      resp_crc8_q  <= 8'h00;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_match_q <= resp_match_d;
      resp_crc8_q  <= resp_crc8_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_match = resp_match_q;
  assign bus.resp_crc8  = resp_crc8_q;
  assign bus.resp_err   = resp_err_q;

endmodule
